// File: rtl/fpmul_stream_master.sv
// +----------------------------------------------------------------------------+
// | fpmul_stream_master : LFSR operand generator and result sink for the FP     |
// | multiplier stream, with bounded in-flight ops and a result log FIFO.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fpmul_stream_master #(
  parameter int          N_OPS           = 16,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          RES_DEPTH       = 8,
  parameter logic [31:0] SEED_A          = 32'h3F80_0001,
  parameter logic [31:0] SEED_B          = 32'h3FC0_0003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic [31:0] res_data,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic        log_rd,
  output logic [31:0] log_dout,
  output logic        log_empty,
  output logic [15:0] issued_cnt,
  output logic [15:0] recv_cnt
);

  localparam int          c_aw      = $clog2(RES_DEPTH);
  localparam logic [15:0] c_n_ops   = 16'(N_OPS);
  localparam logic [15:0] c_max_out = 16'(MAX_OUTSTANDING);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(RES_DEPTH);
  localparam logic [31:0] c_mask    = 32'h8020_0003;
  localparam logic [31:0] c_seed_a  = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] c_seed_b  = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ c_mask) : (s >> 1);
  endfunction

  // Force sign|01|mantissa: exponent 64..127, so products never overflow or go NaN
  function automatic logic [31:0] sanitize(input logic [31:0] s);
    return (s & 32'h9FFF_FFFF) | 32'h2000_0000;
  endfunction

  state_t          r_state, w_state_nx;
  logic [31:0]     r_lfsr_a, r_lfsr_b, w_lfsr_a_nx, w_lfsr_b_nx;
  logic [31:0]     r_op_a, r_op_b, w_op_a_nx, w_op_b_nx;
  logic            r_op_valid, r_res_ready, r_busy, r_done, r_err;
  logic            w_op_valid_nx, w_res_ready_nx, w_busy_nx, w_done_nx, w_err_nx;
  logic [15:0]     r_issued, r_recv, w_issued_nx, w_recv_nx, w_outstanding;
  logic            w_op_fire, w_res_fire, w_push, w_pop;
  logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]   r_log_cnt, w_log_cnt_nx;
  logic [31:0]     r_mem [RES_DEPTH];

  always_comb begin
    w_state_nx    = r_state;
    w_lfsr_a_nx   = r_lfsr_a;
    w_lfsr_b_nx   = r_lfsr_b;
    w_op_a_nx     = r_op_a;
    w_op_b_nx     = r_op_b;
    w_issued_nx   = r_issued;
    w_recv_nx     = r_recv;
    w_err_nx      = r_err;
    w_push        = 1'b0;
    w_op_fire     = r_op_valid && op_ready;
    w_res_fire    = res_valid && r_res_ready;
    w_outstanding = r_issued - r_recv;
    w_pop         = log_rd && (r_log_cnt != '0);

    // A result with nothing in flight is a protocol error and is discarded
    if (w_res_fire) begin
      if (w_outstanding == 16'd0) begin
        w_err_nx = 1'b1;
      end else begin
        w_push    = 1'b1;
        w_recv_nx = r_recv + 16'd1;
      end
    end

    if (w_op_fire) begin
      w_issued_nx = r_issued + 16'd1;
      w_lfsr_a_nx = lfsr_step(r_lfsr_a);
      w_lfsr_b_nx = lfsr_step(r_lfsr_b);
      w_op_a_nx   = sanitize(w_lfsr_a_nx);
      w_op_b_nx   = sanitize(w_lfsr_b_nx);
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx  = S_ISSUE;
          w_issued_nx = 16'd0;
          w_recv_nx   = 16'd0;
          w_err_nx    = 1'b0;
          w_lfsr_a_nx = c_seed_a;
          w_lfsr_b_nx = c_seed_b;
          w_op_a_nx   = sanitize(c_seed_a);
          w_op_b_nx   = sanitize(c_seed_b);
        end
      end
      S_ISSUE: if (w_issued_nx == c_n_ops) w_state_nx = S_DRAIN;
      S_DRAIN: if (w_recv_nx == c_n_ops) w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase

    case ({w_push, w_pop})
      2'b10:   w_log_cnt_nx = r_log_cnt + 1'b1;
      2'b01:   w_log_cnt_nx = r_log_cnt - 1'b1;
      default: w_log_cnt_nx = r_log_cnt;
    endcase

    // Look-ahead on next-cycle counts keeps every output registered
    w_busy_nx      = (w_state_nx == S_ISSUE) || (w_state_nx == S_DRAIN);
    w_done_nx      = (w_state_nx == S_DONE);
    w_op_valid_nx  = (w_state_nx == S_ISSUE) && ((w_issued_nx - w_recv_nx) < c_max_out);
    w_res_ready_nx = w_busy_nx && (w_log_cnt_nx != c_depth);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lfsr_a    <= c_seed_a;
      r_lfsr_b    <= c_seed_b;
      r_op_a      <= 32'h0;
      r_op_b      <= 32'h0;
      r_op_valid  <= 1'b0;
      r_res_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_issued    <= 16'd0;
      r_recv      <= 16'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_log_cnt   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_lfsr_a    <= w_lfsr_a_nx;
      r_lfsr_b    <= w_lfsr_b_nx;
      r_op_a      <= w_op_a_nx;
      r_op_b      <= w_op_b_nx;
      r_op_valid  <= w_op_valid_nx;
      r_res_ready <= w_res_ready_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      r_issued    <= w_issued_nx;
      r_recv      <= w_recv_nx;
      r_log_cnt   <= w_log_cnt_nx;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= res_data;
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign op_valid   = r_op_valid;
  assign res_ready  = r_res_ready;
  assign issued_cnt = r_issued;
  assign recv_cnt   = r_recv;
  assign log_dout   = r_mem[r_rd_ptr];
  assign log_empty  = (r_log_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_fpmul_stream_master.sv
// +----------------------------------------------------------------------------+
// | tb_fpmul_stream_master : directed vector bench for fpmul_stream_master.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fpmul_stream_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_start, a_busy, a_done, a_err, a_op_valid, a_op_ready;
  logic        a_res_valid, a_res_ready, a_log_rd, a_log_empty;
  logic [31:0] a_op_a, a_op_b, a_res_data, a_log_dout;
  logic [15:0] a_issued_cnt, a_recv_cnt;

  logic        b_start, b_busy, b_done, b_err, b_op_valid, b_op_ready;
  logic        b_res_valid, b_res_ready, b_log_rd, b_log_empty;
  logic [31:0] b_op_a, b_op_b, b_res_data, b_log_dout;
  logic [15:0] b_issued_cnt, b_recv_cnt;

  fpmul_stream_master #(.N_OPS(4), .MAX_OUTSTANDING(2), .RES_DEPTH(8)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done), .err(a_err),
    .op_a(a_op_a), .op_b(a_op_b), .op_valid(a_op_valid), .op_ready(a_op_ready),
    .res_data(a_res_data), .res_valid(a_res_valid), .res_ready(a_res_ready),
    .log_rd(a_log_rd), .log_dout(a_log_dout), .log_empty(a_log_empty),
    .issued_cnt(a_issued_cnt), .recv_cnt(a_recv_cnt));

  fpmul_stream_master #(.N_OPS(10), .MAX_OUTSTANDING(2), .RES_DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
    .op_a(b_op_a), .op_b(b_op_b), .op_valid(b_op_valid), .op_ready(b_op_ready),
    .res_data(b_res_data), .res_valid(b_res_valid), .res_ready(b_res_ready),
    .log_rd(b_log_rd), .log_dout(b_log_dout), .log_empty(b_log_empty),
    .issued_cnt(b_issued_cnt), .recv_cnt(b_recv_cnt));

  typedef struct {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] res;
  } vec_t;

  vec_t        tbl [4];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          a_iss_idx = 0;
  bit          a_resp_en = 1'b0;
  bit          a_force = 1'b0;
  logic [31:0] a_pq_data [$];
  int          a_pq_due [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: check/record operand transfers, then drive both responders
  task automatic tick();
    bit a_of, a_rf;
    a_of = !rst && a_op_valid && a_op_ready;
    a_rf = !rst && a_res_valid && a_res_ready;
    if (a_of) begin
      if (a_iss_idx < 4) begin
        chk($sformatf("op_a[%0d]", a_iss_idx), a_op_a, tbl[a_iss_idx].op_a);
        chk($sformatf("op_b[%0d]", a_iss_idx), a_op_b, tbl[a_iss_idx].op_b);
        a_pq_data.push_back(tbl[a_iss_idx].res);
      end else begin
        chk("extra_issue", 32'(a_iss_idx), 32'd3);
        a_pq_data.push_back(32'h0);
      end
      a_pq_due.push_back(cyc + 3);
      a_iss_idx++;
    end
    if (a_rf && a_pq_data.size() > 0) begin
      void'(a_pq_data.pop_front());
      void'(a_pq_due.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    if (a_force) begin
      a_res_valid = 1'b1;
      a_res_data  = 32'hDEAD_BEEF;
    end else if (a_resp_en && a_pq_data.size() > 0 && a_pq_due[0] <= cyc) begin
      a_res_valid = 1'b1;
      a_res_data  = a_pq_data[0];
    end else begin
      a_res_valid = 1'b0;
    end
    b_res_valid = (b_issued_cnt != b_recv_cnt);
    b_res_data  = {16'hB000, b_recv_cnt};
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    a_pq_data.delete();
    a_pq_due.delete();
    a_iss_idx = 0;
  endtask

  task automatic start_a();
    a_iss_idx = 0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  done_cnt;
    bit  seen;
    rst = 1'b1;
    a_start = 0; a_op_ready = 0; a_res_valid = 0; a_res_data = 0; a_log_rd = 0;
    b_start = 0; b_op_ready = 1; b_res_valid = 0; b_res_data = 0; b_log_rd = 0;
    tbl[0] = '{32'h3F80_0001, 32'h3FC0_0003, 32'h1111_0000};
    tbl[1] = '{32'hBFE0_0003, 32'hBFC0_0002, 32'h2222_0001};
    tbl[2] = '{32'hAFD0_0002, 32'h2FE0_0001, 32'h3333_0002};
    tbl[3] = '{32'h27E8_0001, 32'hA7D0_0003, 32'h4444_0003};

    // Reset values
    do_reset(3);
    chk("rst_busy", a_busy, 0);        chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);          chk("rst_op_valid", a_op_valid, 0);
    chk("rst_res_ready", a_res_ready, 0);
    chk("rst_op_a", a_op_a, 0);        chk("rst_op_b", a_op_b, 0);
    chk("rst_issued", a_issued_cnt, 0); chk("rst_recv", a_recv_cnt, 0);
    chk("rst_log_empty", a_log_empty, 1);
    chk("rst_b_busy", b_busy, 0);      chk("rst_b_log_empty", b_log_empty, 1);
    tick();

    // Full run, latency-3 responder, operands checked against the table in tick()
    a_resp_en = 1; a_op_ready = 1;
    start_a();
    chk("first_op_valid", a_op_valid, 1);
    chk("first_busy", a_busy, 1);
    chk("first_op_a", a_op_a, 32'h3F80_0001);
    chk("first_op_b", a_op_b, 32'h3FC0_0003);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_done) done_cnt++;
    end
    chk("run_done_pulses", done_cnt, 1);
    chk("run_issued", a_issued_cnt, 4);
    chk("run_recv", a_recv_cnt, 4);
    chk("run_transfers", a_iss_idx, 4);
    chk("run_busy_end", a_busy, 0);
    chk("run_err", a_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("log[%0d]", i), a_log_dout, tbl[i].res);
      a_log_rd = 1; tick(); a_log_rd = 0;
    end
    chk("log_drained", a_log_empty, 1);

    // Back-pressure stall after the first transfer
    start_a();
    tick();
    chk("stall_pre_idx", a_iss_idx, 1);
    a_op_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_valid[%0d]", i), a_op_valid, 1);
      chk($sformatf("stall_op_a[%0d]", i), a_op_a, tbl[1].op_a);
      chk($sformatf("stall_op_b[%0d]", i), a_op_b, tbl[1].op_b);
    end
    a_op_ready = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (a_done) seen = 1;
    end
    chk("stall_done", seen, 1);
    chk("stall_issued", a_issued_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_log[%0d]", i), a_log_dout, tbl[i].res);
      a_log_rd = 1; tick(); a_log_rd = 0;
    end

    // Silent responder: in-flight cap holds issue at 2
    a_resp_en = 0;
    start_a();
    repeat (20) tick();
    chk("cap_issued", a_issued_cnt, 2);
    chk("cap_transfers", a_iss_idx, 2);
    chk("cap_op_valid", a_op_valid, 0);
    chk("cap_busy", a_busy, 1);
    do_reset(1);
    chk("cap_rst_busy", a_busy, 0);

    // Unsolicited result before any issue
    a_op_ready = 0;
    start_a();
    chk("err_res_ready", a_res_ready, 1);
    a_force = 1; tick(); a_force = 0; tick();
    chk("err_set", a_err, 1);
    chk("err_recv", a_recv_cnt, 0);
    chk("err_log_empty", a_log_empty, 1);
    tick();
    chk("err_sticky", a_err, 1);

    // Reset in the middle of DRAIN
    a_resp_en = 1; a_op_ready = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (a_issued_cnt == 16'd4) seen = 1;
    end
    chk("drain_reached", seen, 1);
    chk("drain_state", {a_busy, a_op_valid, (a_recv_cnt < 16'd4)}, 3'b101);
    do_reset(1);
    chk("drst_busy", a_busy, 0);       chk("drst_issued", a_issued_cnt, 0);
    chk("drst_recv", a_recv_cnt, 0);   chk("drst_err", a_err, 0);
    chk("drst_op_valid", a_op_valid, 0); chk("drst_log_empty", a_log_empty, 1);

    // Log-full back-pressure on the 10-op instance
    b_start = 1; tick(); b_start = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (b_recv_cnt == 16'd8) seen = 1;
    end
    chk("full_reached", seen, 1);
    chk("full_res_ready", b_res_ready, 0);
    repeat (3) tick();
    chk("full_hold_ready", b_res_ready, 0);
    chk("full_hold_recv", b_recv_cnt, 8);
    chk("full_head", b_log_dout, 32'hB000_0000);
    b_log_rd = 1; tick(); b_log_rd = 0;
    chk("pop_res_ready", b_res_ready, 1);
    chk("pop_head", b_log_dout, 32'hB000_0001);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      b_log_rd = 1;
      tick();
      if (b_done) seen = 1;
    end
    b_log_rd = 0;
    chk("b_done", seen, 1);
    chk("b_recv", b_recv_cnt, 10);
    chk("b_err", b_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
